// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future RX path).
package uart_pkg;

  // Line rate used when a UART block is instantiated without an explicit rate.
  localparam int DEFAULT_BAUD = 115200;

  // Serializer frame sequencing: idle, FIFO load, then the three line phases.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Clock cycles per bit period, truncated toward zero.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each period.
// A synchronous clear holds the count at zero so the next period starts aligned.
module uart_baud_tick #(
  parameter int BAUD_DIV = 868,
  localparam int CNT_W   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at zero while cleared, otherwise wrap at the period end.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign tick_o  = !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1-style UART transmitter that drains the TX byte FIFO.
// tx is registered from the next state so the line level lines up with the
// state it belongs to: the start bit appears two cycles after the pop strobe.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = DEFAULT_BAUD,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = calc_baud_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  byte_done
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BIT_W-1:0] DATA_LAST   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST   = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(BAUD_DIV - 2);

  // A one-cycle bit period would leave no room to pre-register byte_done.
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_serializer: BAUD_DIV must be at least 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [BIT_W-1:0]      bit_q;
  logic [BIT_W-1:0]      bit_d;
  logic                  tx_q;
  logic                  tx_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  done_q;
  logic                  done_d;

  logic                  baud_clear;
  logic [CNT_W-1:0]      baud_cnt;
  logic                  baud_tick;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (baud_clear),
    .count_o (baud_cnt),
    .tick_o  (baud_tick)
  );

  // Next-state, FIFO pop and line-level decode for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    baud_clear = 1'b0;

    case (state_q)
      IDLE: begin
        baud_clear = 1'b1;
        if (!empty && !reset) begin
          rd_en   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        baud_clear = 1'b1;
        shift_d    = rd_data;
        bit_d      = '0;
        state_d    = START;
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if ((bit_q == STOP_LAST) && (baud_cnt == CNT_PRELAST)) begin
          done_d = 1'b1;
        end
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign byte_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three instances cover BAUD_DIV=10 with
// one and two stop bits, and the default 868-cycle bit period.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: BAUD_DIV=10, one stop bit.
  logic       empty0, rdEn0, tx0, busy0, done0;
  logic [7:0] rdData0 = 8'h00;
  logic [7:0] mem0 [0:15];
  int         wrPtr0 = 0;
  int         rdPtr0 = 0;
  assign empty0 = (wrPtr0 == rdPtr0);

  // Instance 1: BAUD_DIV=10, two stop bits.
  logic       empty1, rdEn1, tx1, busy1, done1;
  logic [7:0] rdData1 = 8'h00;
  logic [7:0] mem1 [0:15];
  int         wrPtr1 = 0;
  int         rdPtr1 = 0;
  assign empty1 = (wrPtr1 == rdPtr1);

  // Instance 2: default parameters.
  logic       empty2, rdEn2, tx2, busy2, done2;
  logic [7:0] rdData2 = 8'h00;
  logic [7:0] mem2 [0:15];
  int         wrPtr2 = 0;
  int         rdPtr2 = 0;
  assign empty2 = (wrPtr2 == rdPtr2);

  uart_tx_serializer #(
    .CLK_FREQ (1000), .BAUD_RATE (100), .DATA_WIDTH (8), .STOP_BITS (1)
  ) dut0 (
    .clk (clk), .reset (reset), .empty (empty0), .rd_en (rdEn0),
    .rd_data (rdData0), .tx (tx0), .tx_busy (busy0), .byte_done (done0)
  );

  uart_tx_serializer #(
    .CLK_FREQ (1000), .BAUD_RATE (100), .DATA_WIDTH (8), .STOP_BITS (2)
  ) dut1 (
    .clk (clk), .reset (reset), .empty (empty1), .rd_en (rdEn1),
    .rd_data (rdData1), .tx (tx1), .tx_busy (busy1), .byte_done (done1)
  );

  uart_tx_serializer dut2 (
    .clk (clk), .reset (reset), .empty (empty2), .rd_en (rdEn2),
    .rd_data (rdData2), .tx (tx2), .tx_busy (busy2), .byte_done (done2)
  );

  // FIFO read models: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (rdEn0) begin
      rdData0 <= mem0[rdPtr0[3:0]];
      rdPtr0  <= rdPtr0 + 1;
    end
    if (rdEn1) begin
      rdData1 <= mem1[rdPtr1[3:0]];
      rdPtr1  <= rdPtr1 + 1;
    end
    if (rdEn2) begin
      rdData2 <= mem2[rdPtr2[3:0]];
      rdPtr2  <= rdPtr2 + 1;
    end
  end

  // Per-cycle capture of one instance; index 0 is the cycle after rd_en.
  logic txTr   [0:399];
  logic rdTr   [0:399];
  logic busyTr [0:399];
  logic doneTr [0:399];

  task automatic pushByte(input int inst, input logic [7:0] data);
    case (inst)
      0: begin mem0[wrPtr0[3:0]] = data; wrPtr0 = wrPtr0 + 1; end
      1: begin mem1[wrPtr1[3:0]] = data; wrPtr1 = wrPtr1 + 1; end
      default: begin mem2[wrPtr2[3:0]] = data; wrPtr2 = wrPtr2 + 1; end
    endcase
  endtask

  task automatic sampleInst(input int inst, output logic t, output logic r,
                            output logic b, output logic d, output logic e);
    case (inst)
      0: begin t = tx0; r = rdEn0; b = busy0; d = done0; e = empty0; end
      1: begin t = tx1; r = rdEn1; b = busy1; d = done1; e = empty1; end
      default: begin t = tx2; r = rdEn2; b = busy2; d = done2; e = empty2; end
    endcase
  endtask

  task automatic waitRdEn(input int inst, input int limit, output bit found);
    logic t, r, b, d, e;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      #1;
      sampleInst(inst, t, r, b, d, e);
      if (r) begin
        found = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic captureTrace(input int inst, input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sampleInst(inst, txTr[i], rdTr[i], busyTr[i], doneTr[i], e);
    end
  endtask

  // Reads a byte from the trace by sampling the middle of each data bit.
  function automatic logic [7:0] decodeAt(input int base, input int div);
    logic [7:0] v;
    v = 8'h00;
    for (int b = 0; b < 8; b++) begin
      v[b] = txTr[base + div * (1 + b) + div / 2];
    end
    return v;
  endfunction

  task automatic test_reset();
    logic t, r, b, d, e;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int inst = 0; inst < 3; inst++) begin
      sampleInst(inst, t, r, b, d, e);
      checks++;
      if (t !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx inst%0d: got %b expected 1", inst, t); end
      checks++;
      if (r !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en inst%0d: got %b expected 0", inst, r); end
      checks++;
      if (b !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy inst%0d: got %b expected 0", inst, b); end
      checks++;
      if (d !== 1'b0) begin errors++; $display("[TB] FAIL reset_done inst%0d: got %b expected 0", inst, d); end
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_empty();
    int badRd, badTx, badBusy;
    badRd = 0; badTx = 0; badBusy = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rdEn0 !== 1'b0) badRd++;
      if (tx0 !== 1'b1) badTx++;
      if (busy0 !== 1'b0) badBusy++;
    end
    checks++;
    if (badRd != 0) begin errors++; $display("[TB] FAIL idle_rd_en: %0d bad cycles, expected 0", badRd); end
    checks++;
    if (badTx != 0) begin errors++; $display("[TB] FAIL idle_tx: %0d bad cycles, expected 0", badTx); end
    checks++;
    if (badBusy != 0) begin errors++; $display("[TB] FAIL idle_busy: %0d bad cycles, expected 0", badBusy); end
  endtask

  task automatic test_single_byte();
    logic expLvl [0:9];
    bit   found;
    int   waveBad, doneCount, doneIdx, busyBad, rdCount;
    expLvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pushByte(0, 8'hA5);
    waitRdEn(0, 20, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL single_rd_en: got none expected one pulse"); return; end
    captureTrace(0, 102);
    waveBad = 0; doneCount = 0; doneIdx = -1; busyBad = 0; rdCount = 0;
    if (txTr[0] !== 1'b1) waveBad++;
    if (txTr[101] !== 1'b1) waveBad++;
    for (int i = 1; i <= 100; i++) begin
      if (txTr[i] !== expLvl[(i - 1) / 10]) waveBad++;
    end
    for (int i = 0; i <= 101; i++) begin
      if (doneTr[i] === 1'b1) begin doneCount++; doneIdx = i; end
      if (rdTr[i] !== 1'b0) rdCount++;
      if ((i <= 100) && (busyTr[i] !== 1'b1)) busyBad++;
    end
    checks++;
    if (waveBad != 0) begin errors++; $display("[TB] FAIL single_wave: %0d wrong cycles, expected 0", waveBad); end
    checks++;
    if (doneCount != 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d expected 1", doneCount); end
    checks++;
    if (doneIdx != 100) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d expected 100", doneIdx); end
    checks++;
    if (busyBad != 0) begin errors++; $display("[TB] FAIL single_busy_high: %0d low cycles, expected 0", busyBad); end
    checks++;
    if (busyTr[101] !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_low: got %b expected 0", busyTr[101]); end
    checks++;
    if (rdCount != 0) begin errors++; $display("[TB] FAIL single_extra_rd_en: got %0d expected 0", rdCount); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expBytes [0:2];
    logic [7:0] got;
    bit         found;
    int         rdIdx [0:1];
    int         rdCount;
    expBytes = '{8'h00, 8'hFF, 8'h55};
    pushByte(0, 8'h00);
    pushByte(0, 8'hFF);
    pushByte(0, 8'h55);
    waitRdEn(0, 20, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL b2b_first_rd_en: got none expected one pulse"); return; end
    captureTrace(0, 320);
    rdCount = 0; rdIdx[0] = -1; rdIdx[1] = -1;
    for (int i = 0; i < 320; i++) begin
      if (rdTr[i] === 1'b1) begin
        if (rdCount < 2) rdIdx[rdCount] = i;
        rdCount++;
      end
    end
    checks++;
    if (rdCount != 2) begin errors++; $display("[TB] FAIL b2b_rd_count: got %0d expected 2", rdCount); end
    checks++;
    if ((rdIdx[0] != 101) || (rdIdx[1] != 203)) begin
      errors++;
      $display("[TB] FAIL b2b_rd_spacing: got %0d,%0d expected 101,203", rdIdx[0], rdIdx[1]);
    end
    for (int f = 0; f < 3; f++) begin
      got = decodeAt(f * 102 + 1, 10);
      checks++;
      if (got !== expBytes[f]) begin
        errors++;
        $display("[TB] FAIL b2b_byte%0d: got %h expected %h", f, got, expBytes[f]);
      end
    end
    checks++;
    if (empty0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty_after: got %b expected 1", empty0); end
  endtask

  task automatic test_reset_mid_frame();
    bit         found;
    int         doneCount, rdBad, lowCount, doneIdx;
    logic [7:0] got;
    pushByte(0, 8'h3C);
    pushByte(0, 8'h96);
    waitRdEn(0, 20, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL rst_first_rd_en: got none expected one pulse"); return; end
    captureTrace(0, 45);
    doneCount = 0;
    for (int i = 0; i < 45; i++) if (doneTr[i] === 1'b1) doneCount++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (tx0 !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_tx: got %b expected 1", tx0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy0); end
    if (done0 === 1'b1) doneCount++;
    rdBad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdEn0 !== 1'b0) rdBad++;
      if (done0 === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount != 0) begin errors++; $display("[TB] FAIL rst_no_done: got %0d pulses expected 0", doneCount); end
    checks++;
    if (rdBad != 0) begin errors++; $display("[TB] FAIL rst_rd_en_in_reset: got %0d cycles expected 0", rdBad); end
    reset = 1'b0;
    waitRdEn(0, 5, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL rst_restart_rd_en: got none expected one pulse"); return; end
    captureTrace(0, 102);
    lowCount = 0; doneIdx = -1;
    for (int i = 1; i <= 10; i++) if (txTr[i] === 1'b0) lowCount++;
    for (int i = 0; i < 102; i++) if ((doneTr[i] === 1'b1) && (doneIdx < 0)) doneIdx = i;
    checks++;
    if ((txTr[0] !== 1'b1) || (lowCount != 10)) begin
      errors++;
      $display("[TB] FAIL rst_clean_start: got pre=%b low=%0d expected pre=1 low=10", txTr[0], lowCount);
    end
    got = decodeAt(1, 10);
    checks++;
    if (got !== 8'h96) begin errors++; $display("[TB] FAIL rst_next_byte: got %h expected 96", got); end
    checks++;
    if (doneIdx != 100) begin errors++; $display("[TB] FAIL rst_next_done: got %0d expected 100", doneIdx); end
  endtask

  task automatic test_stop_bits_two();
    bit         found;
    int         stopHigh, doneIdx, rdIdx;
    logic [7:0] got;
    pushByte(1, 8'h81);
    pushByte(1, 8'h81);
    waitRdEn(1, 20, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL stop2_rd_en: got none expected one pulse"); return; end
    captureTrace(1, 115);
    stopHigh = 0; doneIdx = -1; rdIdx = -1;
    for (int i = 91; i <= 110; i++) if (txTr[i] === 1'b1) stopHigh++;
    for (int i = 0; i < 115; i++) begin
      if ((doneTr[i] === 1'b1) && (doneIdx < 0)) doneIdx = i;
      if ((rdTr[i] === 1'b1) && (rdIdx < 0)) rdIdx = i;
    end
    got = decodeAt(1, 10);
    checks++;
    if (got !== 8'h81) begin errors++; $display("[TB] FAIL stop2_byte: got %h expected 81", got); end
    checks++;
    if (stopHigh != 20) begin errors++; $display("[TB] FAIL stop2_stop_len: got %0d expected 20", stopHigh); end
    checks++;
    if (doneIdx != 110) begin errors++; $display("[TB] FAIL stop2_done_cycle: got %0d expected 110", doneIdx); end
    checks++;
    if (rdIdx != 111) begin errors++; $display("[TB] FAIL stop2_rd_spacing: got %0d expected 111", rdIdx); end
    checks++;
    if (txTr[113] !== 1'b0) begin errors++; $display("[TB] FAIL stop2_next_start: got %b expected 0", txTr[113]); end
  endtask

  task automatic test_default_params();
    bit   found, inStart;
    logic t, r, b, d, e;
    int   startLen, doneIdx, busyOff;
    pushByte(2, 8'h41);
    waitRdEn(2, 20, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL dflt_rd_en: got none expected one pulse"); return; end
    startLen = 0; inStart = 1'b1; doneIdx = -1; busyOff = -1;
    for (int i = 0; (i < 9000) && (busyOff < 0); i++) begin
      @(negedge clk);
      sampleInst(2, t, r, b, d, e);
      if ((i >= 1) && inStart) begin
        if (t === 1'b0) startLen++;
        else inStart = 1'b0;
      end
      if ((d === 1'b1) && (doneIdx < 0)) doneIdx = i;
      if ((b === 1'b0) && (busyOff < 0)) busyOff = i;
    end
    checks++;
    if (startLen != 868) begin errors++; $display("[TB] FAIL dflt_start_len: got %0d expected 868", startLen); end
    checks++;
    if (doneIdx != 8680) begin errors++; $display("[TB] FAIL dflt_frame_len: got %0d expected 8680", doneIdx); end
    checks++;
    if (busyOff != 8681) begin errors++; $display("[TB] FAIL dflt_busy_off: got %0d expected 8681", busyOff); end
  endtask

  // Runs the scenarios in order and prints the summary.
  initial begin
    test_reset();
    test_idle_empty();
    test_single_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_stop_bits_two();
    test_default_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
